// File: rtl/lif_array.sv
// Array of independent leaky integrate-and-fire neurons with per-channel refractory
// timers and a saturating spike counter shared across all channels.
module lif_array #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int THRESHOLD  = 200,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRAC     = 2,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [CHANNELS*WIDTH-1:0]  current,
  input  logic                       clr_cnt,
  output logic [CHANNELS*WIDTH-1:0]  state,
  output logic [CHANNELS-1:0]        spike,
  output logic [CNT_W-1:0]           spike_total
);

  localparam logic [WIDTH-1:0] THRESH     = WIDTH'(THRESHOLD);
  localparam logic [3:0]       REFRAC_VAL = 4'(REFRAC);
  localparam int               PW         = $clog2(CHANNELS + 1);
  localparam int               TW         = CNT_W + PW;

  logic [CHANNELS-1:0] fire;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [WIDTH-1:0] state_reg;
      logic             spike_reg;
      logic [3:0]       r_reg;
      logic [WIDTH-1:0] cur;
      logic [WIDTH-1:0] leaked;
      logic [WIDTH:0]   sum;
      logic [WIDTH-1:0] clamped;

      assign cur     = current[gi*WIDTH +: WIDTH];
      assign leaked  = state_reg - (state_reg >> LEAK_SHIFT);
      assign sum     = {1'b0, leaked} + {1'b0, cur};
      assign clamped = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
      // Firing is decided combinationally so the counter sees the same edge's spikes.
      assign fire[gi] = en && (r_reg == 4'd0) && (clamped >= THRESH);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_reg <= '0;
          spike_reg <= 1'b0;
          r_reg     <= 4'd0;
        end else if (en) begin
          if (r_reg != 4'd0) begin
            state_reg <= '0;
            spike_reg <= 1'b0;
            r_reg     <= r_reg - 4'd1;
          end else if (fire[gi]) begin
            state_reg <= '0;
            spike_reg <= 1'b1;
            r_reg     <= REFRAC_VAL;
          end else begin
            state_reg <= clamped;
            spike_reg <= 1'b0;
          end
        end else begin
          spike_reg <= 1'b0;
        end
      end

      assign state[gi*WIDTH +: WIDTH] = state_reg;
      assign spike[gi]                = spike_reg;
    end
  endgenerate

  logic [PW-1:0]    pop;
  logic [TW-1:0]    total_sum;
  logic [CNT_W-1:0] total_reg;
  logic [CNT_W-1:0] total_next;
  localparam logic [TW-1:0] CNT_MAX_EXT = {{PW{1'b0}}, {CNT_W{1'b1}}};

  always_comb begin
    pop = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      pop = pop + PW'(fire[i]);
    end
    total_sum  = {{PW{1'b0}}, total_reg} + {{CNT_W{1'b0}}, pop};
    total_next = (total_sum > CNT_MAX_EXT) ? {CNT_W{1'b1}} : total_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      total_reg <= '0;
    end else begin
      total_reg <= total_next;
    end
  end

  assign spike_total = total_reg;

endmodule

// File: doc/lif_array.md
LIF_ARRAY -- requirements
Module: lif_array

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each membrane state and input current.
REQ-002 Parameter CHANNELS, default 4: number of independent neurons.
REQ-003 Parameter THRESHOLD, default 200: firing level, valid range 1..2^WIDTH-1.
REQ-004 Parameter LEAK_SHIFT, default 1: leak per cycle is state >> LEAK_SHIFT, valid range 1..WIDTH-1.
REQ-005 Parameter REFRAC, default 2: refractory length in enabled cycles, valid range 0..15.
REQ-006 Parameter CNT_W, default 16: width of the spike counter.
REQ-007 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-009 Port en, input, 1 bit: global integrate enable.
REQ-010 Port current, input, CHANNELS*WIDTH bits: unsigned input current; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-011 Port clr_cnt, input, 1 bit: synchronous clear of spike_total.
REQ-012 Port state, output, CHANNELS*WIDTH bits: registered membrane state per channel, packed as current.
REQ-013 Port spike, output, CHANNELS bits: registered one-cycle spike pulse per channel.
REQ-014 Port spike_total, output, CNT_W bits: saturating count of all spikes across all channels.

Function
REQ-015 Each channel holds three registers: state (WIDTH), spike (1) and refractory counter r (4 bits).
REQ-016 All channels are identical and fully independent, and all update in the same cycle.
REQ-017 With en=1 and r>0 at an edge: state<=0, spike<=0, r<=r-1, and current is ignored.
REQ-018 With en=1 and r=0: compute sum = state - (state>>LEAK_SHIFT) + current in WIDTH+1 bits.
REQ-019 Sum saturation: if sum > 2^WIDTH-1, sum is clamped to 2^WIDTH-1 before the threshold compare.
REQ-020 If the clamped sum >= THRESHOLD: state<=0, spike<=1, r<=REFRAC.
REQ-021 Otherwise: state<=clamped sum, spike<=0, r unchanged (remains 0).
REQ-022 Latency: a spike is visible on the same edge that the crossing sum is computed, so spike and state=0 appear together.
REQ-023 spike is high for exactly one cycle per firing.
REQ-024 Back-to-back spikes on one channel are only possible when REFRAC=0.
REQ-025 With en=0: state and r hold their values, spike<=0, and current is ignored.
REQ-026 spike_total update: on each edge, spike_total <= spike_total + popcount of the spike bits being set on that edge.
REQ-027 spike_total therefore matches the spike outputs visible after that edge.
REQ-028 spike_total saturates at 2^CNT_W-1 and never wraps.
REQ-029 clr_cnt=1 sets spike_total<=0; clear has priority over any simultaneous increment, and spikes firing on that edge are not counted.
REQ-030 clr_cnt does not affect state, spike or r.

Reset
REQ-031 With rst_n=0 at a rising edge: all state=0, all spike=0, all r=0, spike_total=0.
REQ-032 Reset has priority over en and clr_cnt.
REQ-033 Reset asserted mid-refractory or mid-integration aborts that activity; the first edge after release behaves as from a fresh state of 0 with r=0.

Verification
All scenarios use the defaults (WIDTH=8, CHANNELS=4, THRESHOLD=200, LEAK_SHIFT=1, REFRAC=2) unless stated.
REQ-034 Integrate and fire: ch0 current=110, en=1 from reset.
  - ch0 state across edges: 110, 165, 193, then 0 with spike[0]=1 (sum 207).
  - Next two edges: state 0, spike 0.
  - Following edge: state 110.
  - spike_total = 1 after the firing edge.
REQ-035 Sub-threshold: ch1 current=60 for 20 cycles.
  - State sequence 60, 90, 105, 113, ..., settling at 119/120.
  - spike[1] never asserts.
REQ-036 Saturation: instance with THRESHOLD=255, ch0 current=200.
  - State 200, then the sum of 300 clamps to 255: spike=1, state=0.
REQ-037 Simultaneous spikes and clear.
  - All four channels current=255: all spike on the first edge and spike_total=4.
  - clr_cnt=1 on the edge where all channels fire again: spike_total=0.
REQ-038 Enable and reset.
  - ch0 at state 165: drop en for 3 cycles; state holds 165 and spike stays 0.
  - Reassert en: next state 193.
  - Assert rst_n=0 during refractory: all outputs 0; after release, ch0 starts again at 110.
REQ-039 Counter saturation: instance with CNT_W=3, all channels current=255, REFRAC=0.
  - spike_total reads 4, then 7, and holds at 7.
